// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver: mid-bit 3-sample majority vote, false-start rejection,
// framing/parity/overrun reporting and a valid/ready output holding register.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic [2:0]           curr_state
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned MID   = CLKS_PER_BIT / 2;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;

    logic [2:0]             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [1:0]             smp;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   stop_err;

    logic                   at_res_c;
    logic                   at_end_c;
    logic                   vote_c;
    logic                   done_c;
    logic                   par_x_c;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign curr_state = state;

    // Input synchroniser plus one-cycle delay for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    assign at_res_c = (cnt == CNT_W'(MID + 1));
    assign at_end_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign vote_c   = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign par_x_c  = (^shreg) ^ par_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
        end
    end

    // Next-state logic; the last stop bit completes the frame at its resolve point
    always_comb begin
        state_n   = state;
        cnt_n     = at_end_c ? '0 : cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (rx_s_d && !rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (at_res_c && vote_c) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (at_end_c) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (at_end_c) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (at_end_c) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (at_res_c && (bit_idx == IDX_W'(STOP_BITS - 1))) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    done_c    = 1'b1;
                end else if (at_end_c) begin
                    bit_idx_n = bit_idx + IDX_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                bit_idx_n = '0;
            end
        endcase
    end

    // Sampling, shift register and the output holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp           <= 2'b11;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stop_err      <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (cnt == CNT_W'(MID - 1)) smp[0] <= rx_s;
            if (cnt == CNT_W'(MID))     smp[1] <= rx_s;
            if (state == IDLE) stop_err <= 1'b0;
            if (at_res_c) begin
                case (state)
                    DATA:    shreg <= {vote_c, shreg[DATA_BITS-1:1]};
                    PARITY:  par_bit <= vote_c;
                    STOP:    if (!vote_c) stop_err <= 1'b1;
                    default: ;
                endcase
            end
            overrun_error <= 1'b0;
            if (done_c) begin
                data_out      <= shreg;
                parity_error  <= (PARITY_MODE == 1) ? par_x_c :
                                 (PARITY_MODE == 2) ? ~par_x_c : 1'b0;
                framing_error <= stop_err | ~vote_c;
                data_valid    <= 1'b1;
                overrun_error <= data_valid & ~data_ready;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_param: three configurations driven with directed frames.
module tb_uart_rx_param;

    localparam int CPB = 8;
    localparam int L0  = (1 + 8 + 1 + 1 - 1) * CPB + CPB / 2 + 2;

    typedef struct packed {
        logic [15:0] d;
        logic        pe;
        logic        fe;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        rx0, rdy0, dv0, pe0, fe0, ov0;
    logic [7:0]  dout0;
    logic [2:0]  st0;
    logic        rx1, rdy1, dv1, pe1, fe1, ov1;
    logic [7:0]  dout1;
    logic [2:0]  st1;
    logic        rx2, rdy2, dv2, pe2, fe2, ov2;
    logic [11:0] dout2;
    logic [2:0]  st2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ov0 = 0, n_ov1 = 0, n_ov2 = 0;
    int vhi0 = 0;
    int t_start0 = 0, t_valid0 = 0;

    uart_rx_param #(.CLKS_PER_BIT(CPB)) u_dut0 (
        .clk(clk), .reset(rst_n), .rx(rx0), .data_out(dout0), .data_valid(dv0),
        .data_ready(rdy0), .parity_error(pe0), .framing_error(fe0),
        .overrun_error(ov0), .curr_state(st0));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .rx(rx1), .data_out(dout1), .data_valid(dv1),
        .data_ready(rdy1), .parity_error(pe1), .framing_error(fe1),
        .overrun_error(ov1), .curr_state(st1));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(12), .PARITY_MODE(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .rx(rx2), .data_out(dout2), .data_valid(dv2),
        .data_ready(rdy2), .parity_error(pe2), .framing_error(fe2),
        .overrun_error(ov2), .curr_state(st2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic exp_t mk(input logic [15:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_frame(input string nm, input exp_t act, input exp_t exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got data=0x%0h pe=%0b fe=%0b expected data=0x%0h pe=%0b fe=%0b",
                     nm, act.d, act.pe, act.fe, exp.d, exp.pe, exp.fe);
        end
    endtask

    task automatic note_unexpected(input string nm);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: got an output frame, expected none", nm);
    endtask

    // Monitor: pops the scoreboard on every consumed frame, tracks pulses and timing
    initial begin
        logic [2:0] ps0;
        logic       pdv0;
        exp_t       e;
        ps0  = 3'd0;
        pdv0 = 1'b0;
        forever begin
            @(negedge clk);
            if (dv0 && rdy0) begin
                if (q0.size() == 0) note_unexpected("frame0");
                else begin
                    e = q0.pop_front();
                    cmp_frame("frame0", mk({8'h00, dout0}, pe0, fe0), e);
                end
            end
            if (dv1 && rdy1) begin
                if (q1.size() == 0) note_unexpected("frame1");
                else begin
                    e = q1.pop_front();
                    cmp_frame("frame1", mk({8'h00, dout1}, pe1, fe1), e);
                end
            end
            if (dv2 && rdy2) begin
                if (q2.size() == 0) note_unexpected("frame2");
                else begin
                    e = q2.pop_front();
                    cmp_frame("frame2", mk({4'h0, dout2}, pe2, fe2), e);
                end
            end
            if (ov0) n_ov0 = n_ov0 + 1;
            if (ov1) n_ov1 = n_ov1 + 1;
            if (ov2) n_ov2 = n_ov2 + 1;
            if (dv0) vhi0 = vhi0 + 1;
            if (st0 == 3'd1 && ps0 == 3'd0) t_start0 = cyc;
            if (dv0 && !pdv0) t_valid0 = cyc;
            ps0  = st0;
            pdv0 = dv0;
        end
    end

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    function automatic logic [31:0] build(input logic [15:0] d, input int dbits, input int pmode,
                                          input int stops, input logic flip_par, input logic stop_v);
        logic [31:0] b;
        logic        p;
        int          n;
        b = '0;
        p = 1'b0;
        n = 1;
        for (int i = 0; i < dbits; i++) begin
            b[n] = d[i];
            p    = p ^ d[i];
            n    = n + 1;
        end
        if (pmode != 0) begin
            b[n] = ((pmode == 2) ? ~p : p) ^ flip_par;
            n    = n + 1;
        end
        for (int i = 0; i < stops; i++) begin
            b[n] = stop_v;
            n    = n + 1;
        end
        return b;
    endfunction

    // Each bit lasts CPB cycles; glitch_bit gets a one-cycle inversion at mid-bit
    task automatic drive_bits(input int inst, input logic [31:0] b, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            set_rx(inst, b[i]);
            if (i == glitch_bit) begin
                repeat (5) @(posedge clk);
                #1 set_rx(inst, ~b[i]);
                @(posedge clk);
                #1 set_rx(inst, b[i]);
                repeat (2) @(posedge clk);
                #1;
            end else begin
                repeat (CPB) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send(input int inst, input logic [15:0] d, input int dbits, input int pmode,
                        input int stops, input logic flip_par, input logic stop_v, input int glitch_bit);
        drive_bits(inst, build(d, dbits, pmode, stops, flip_par, stop_v),
                   1 + dbits + ((pmode != 0) ? 1 : 0) + stops, glitch_bit);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          base;
        int          seen;
        logic [2:0]  ps;
        logic [31:0] b;

        rst_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        wait_cycles(3);
        check("rst_dout0", 32'(dout0), 0);
        check("rst_valid0", 32'(dv0), 0);
        check("rst_perr0", 32'(pe0), 0);
        check("rst_ferr0", 32'(fe0), 0);
        check("rst_ovr0", 32'(ov0), 0);
        check("rst_state0", 32'(st0), 0);
        check("rst_state2", 32'(st2), 0);
        rst_n = 1'b1;
        wait_cycles(4);

        // Clean even-parity frame, consumer always ready
        rdy0 = 1'b1;
        vhi0 = 0;
        q0.push_back(mk(16'h00A5, 1'b0, 1'b0));
        send(0, 16'h00A5, 8, 1, 1, 1'b0, 1'b1, -1);
        wait_cycles(12);
        check("latency0", 32'(t_valid0 - t_start0), 32'(L0));
        check("valid_cycles0", 32'(vhi0), 1);

        // Three-cycle start glitch is rejected
        vhi0 = 0;
        set_rx(0, 1'b0);
        wait_cycles(3);
        set_rx(0, 1'b1);
        wait_cycles(20);
        check("glitch_start_seen", 32'(t_start0 > t_valid0), 1);
        check("glitch_state0", 32'(st0), 0);
        check("glitch_valid0", 32'(vhi0), 0);

        // One-cycle glitch mid data bit 3 is voted out
        q0.push_back(mk(16'h00FF, 1'b0, 1'b0));
        send(0, 16'h00FF, 8, 1, 1, 1'b0, 1'b1, 4);
        wait_cycles(12);

        // Odd parity with flipped parity bit
        rdy1 = 1'b1;
        q1.push_back(mk(16'h003C, 1'b1, 1'b0));
        send(1, 16'h003C, 8, 2, 1, 1'b1, 1'b1, -1);
        wait_cycles(12);

        // Stop bit 0, line stays low: frame delivered with framing error, no new start
        rdy0 = 1'b0;
        send(0, 16'h0055, 8, 1, 1, 1'b0, 1'b0, -1);
        wait_cycles(40);
        check("ferr_valid0", 32'(dv0), 1);
        check("ferr_flag0", 32'(fe0), 1);
        check("ferr_perr0", 32'(pe0), 0);
        check("ferr_data0", 32'(dout0), 32'h55);
        check("ferr_state0", 32'(st0), 0);
        q0.push_back(mk(16'h0055, 1'b0, 1'b1));
        set_rx(0, 1'b1);
        rdy0 = 1'b1;
        wait_cycles(2);
        rdy0 = 1'b0;
        wait_cycles(4);
        check("ferr_consumed0", 32'(dv0), 0);

        // Back-to-back frames while stalled: overrun, newest word kept
        base = n_ov0;
        send(0, 16'h0011, 8, 1, 1, 1'b0, 1'b1, -1);
        send(0, 16'h0022, 8, 1, 1, 1'b0, 1'b1, -1);
        wait_cycles(12);
        check("ovr_pulses0", 32'(n_ov0 - base), 1);
        check("ovr_data0", 32'(dout0), 32'h22);
        check("ovr_valid0", 32'(dv0), 1);
        q0.push_back(mk(16'h0022, 1'b0, 1'b0));
        rdy0 = 1'b1;
        wait_cycles(2);
        rdy0 = 1'b0;
        wait_cycles(4);

        // Back-to-back frames with ready raised exactly on the second completion edge
        base = n_ov0;
        q0.push_back(mk(16'h0011, 1'b0, 1'b0));
        q0.push_back(mk(16'h0022, 1'b0, 1'b0));
        fork
            begin
                send(0, 16'h0011, 8, 1, 1, 1'b0, 1'b1, -1);
                send(0, 16'h0022, 8, 1, 1, 1'b0, 1'b1, -1);
            end
            begin
                seen = 0;
                ps   = st0;
                for (int i = 0; i < 400 && seen < 2; i++) begin
                    @(negedge clk);
                    if (st0 == 3'd1 && ps == 3'd0) seen = seen + 1;
                    ps = st0;
                end
                check("b2b_starts0", 32'(seen), 2);
                if (seen == 2) begin
                    repeat (L0 - 1) @(posedge clk);
                    #1 rdy0 = 1'b1;
                end
            end
        join
        wait_cycles(12);
        check("b2b_no_ovr0", 32'(n_ov0 - base), 0);
        rdy0 = 1'b0;

        // 12-bit, no parity, 2 stop bits: hold a word, then reset mid-frame
        send(2, 16'h05A3, 12, 0, 2, 1'b0, 1'b1, -1);
        wait_cycles(14);
        check("hold_valid2", 32'(dv2), 1);
        check("hold_data2", 32'(dout2), 32'h5A3);
        check("hold_ferr2", 32'(fe2), 0);
        b = build(16'h0ABC, 12, 0, 2, 1'b0, 1'b1);
        drive_bits(2, b, 6, -1);
        set_rx(2, b[6]);
        wait_cycles(4);
        check("mid_state2", 32'(st2), 2);
        rst_n = 1'b0;
        set_rx(2, 1'b1);
        wait_cycles(2);
        check("mrst_data2", 32'(dout2), 0);
        check("mrst_valid2", 32'(dv2), 0);
        check("mrst_perr2", 32'(pe2), 0);
        check("mrst_ferr2", 32'(fe2), 0);
        check("mrst_ovr2", 32'(ov2), 0);
        check("mrst_state2", 32'(st2), 0);
        rst_n = 1'b1;
        wait_cycles(4);
        rdy2 = 1'b1;
        q2.push_back(mk(16'h0ABC, 1'b0, 1'b0));
        send(2, 16'h0ABC, 12, 0, 2, 1'b0, 1'b1, -1);
        wait_cycles(14);

        check("left_q0", 32'(q0.size()), 0);
        check("left_q1", 32'(q1.size()), 0);
        check("left_q2", 32'(q2.size()), 0);
        check("ovr_count1", 32'(n_ov1), 0);
        check("ovr_count2", 32'(n_ov2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
